instr_fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined processor. Sits directly upstream of instruction decode.
- Keeps the program counter and drives the address of a synchronous instruction memory with 1-cycle read latency.
- Presents a 20-bit instruction to decode, tagged with its PC and a valid bit.
- Supports decode stall, branch/jump redirect, and a HALT opcode that freezes fetch.

---
 rtl/instr_fetch_stage.sv | 113 +++++++++++
 tb/tb_instr_fetch_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: owns the program counter, addresses a synchronous
// instruction memory (1-cycle read latency) and hands each returned 20-bit
// word to decode together with its PC and a valid flag. Handles decode stall,
// branch/jump redirect and a HALT opcode that freezes fetching.
module instr_fetch_stage #(
  parameter int          ADDR_W  = 8,
  parameter logic [3:0]  HALT_OP = 4'b1111
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [19:0]       imem_data,
  output logic [19:0]       instruction,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              halted
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] out_pc_q;
  logic              out_valid_q;
  logic              halted_q;

  logic [ADDR_W-1:0] pc_inc_d;
  logic [ADDR_W-1:0] redirect_inc_d;
  logic              halt_seen_d;

  // Incremented addresses wrap naturally modulo 2^ADDR_W; the word on
  // imem_data belongs to out_pc_q, so a HALT is only meaningful when valid.
  always_comb begin
    pc_inc_d       = pc_q + ONE;
    redirect_inc_d = redirect_pc + ONE;
    halt_seen_d    = out_valid_q && (imem_data[19:16] == HALT_OP);
  end

  // Memory address: a redirect target wins; a stalled RUN re-reads the held
  // instruction's address so the returned word stays stable; otherwise fetch pc.
  always_comb begin
    imem_addr = pc_q;
    if (redirect) begin
      imem_addr = redirect_pc;
    end else if (state_q == RUN && stall) begin
      imem_addr = out_pc_q;
    end
  end

  // Fetch FSM with registered outputs; priority reset > redirect > stall > HALT > normal.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q     <= BOOT;
      pc_q        <= '0;
      out_pc_q    <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else if (redirect) begin
      state_q     <= RUN;
      pc_q        <= redirect_inc_d;
      out_pc_q    <= redirect_pc;
      out_valid_q <= 1'b1;
      halted_q    <= 1'b0;
    end else begin
      unique case (state_q)
        BOOT: begin
          state_q     <= RUN;
          pc_q        <= pc_inc_d;
          out_pc_q    <= pc_q;
          out_valid_q <= 1'b1;
          halted_q    <= 1'b0;
        end
        RUN: begin
          if (stall) begin
            state_q <= RUN;
          end else if (halt_seen_d) begin
            state_q     <= HALTED;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b1;
          end else begin
            pc_q        <= pc_inc_d;
            out_pc_q    <= pc_q;
            out_valid_q <= 1'b1;
          end
        end
        HALTED: begin
          out_valid_q <= 1'b0;
          halted_q    <= 1'b1;
        end
        default: begin
          state_q     <= BOOT;
          out_valid_q <= 1'b0;
          halted_q    <= 1'b0;
        end
      endcase
    end
  end

  assign instruction = imem_data;
  assign instr_pc    = out_pc_q;
  assign instr_valid = out_valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: a synchronous memory model, a behavioural
// reference of what decode should see, a per-cycle compare process and a
// directed sequence with hand-computed literal expectations.
module tb_instr_fetch_stage;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr;
  logic [19:0] imem_data;
  logic [19:0] instruction;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        halted;

  int checks = 0;
  int passes = 0;

  instr_fetch_stage #(.ADDR_W(8), .HALT_OP(4'b1111)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  // 10-unit clock period
  always #5 Clock = ~Clock;

  // Instruction memory with one cycle of read latency
  logic [19:0] mem [256];
  always @(posedge Clock) imem_data <= mem[imem_addr];

  // Reference: the instruction decode is being shown, the next address to
  // fetch, and whether fetching is booting, running or frozen.
  typedef enum {M_BOOT, M_RUN, M_HALT} mmode_t;
  mmode_t     mMode = M_BOOT;
  logic [7:0] mFetch = 8'd0;
  logic [7:0] mShownPc = 8'd0;
  logic       mValid = 1'b0;
  bit         mReady = 1'b0;

  always @(posedge Clock) begin
    if (!Resetn) begin
      mReady   = 1'b1;
      mMode    = M_BOOT;
      mFetch   = 8'd0;
      mShownPc = 8'd0;
      mValid   = 1'b0;
    end else if (mReady) begin
      if (redirect) begin
        mShownPc = redirect_pc;
        mFetch   = 8'(redirect_pc + 1);
        mValid   = 1'b1;
        mMode    = M_RUN;
      end else if (mMode == M_BOOT) begin
        mShownPc = mFetch;
        mFetch   = 8'(mFetch + 1);
        mValid   = 1'b1;
        mMode    = M_RUN;
      end else if (mMode == M_RUN && !stall) begin
        if (mValid && mem[mShownPc][19:16] == 4'hF) begin
          mValid = 1'b0;
          mMode  = M_HALT;
        end else begin
          mShownPc = mFetch;
          mFetch   = 8'(mFetch + 1);
          mValid   = 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic rn, input logic st, input logic rd, input logic [7:0] rpc);
    Resetn      = rn;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Compare DUT against the reference every cycle, mid-cycle
  always @(negedge Clock) begin
    if (mReady) begin
      logic [7:0] expAddr;
      expAddr = redirect ? redirect_pc :
                ((mMode == M_RUN && stall) ? mShownPc : mFetch);
      checkOutput("mdl_imem_addr", 32'(imem_addr), 32'(expAddr));
      checkOutput("mdl_valid", 32'(instr_valid), 32'(mValid));
      checkOutput("mdl_halted", 32'(halted), 32'(mMode == M_HALT));
      checkOutput("mdl_instr_pc", 32'(instr_pc), 32'(mShownPc));
      if (mValid) checkOutput("mdl_instruction", 32'(instruction), 32'(mem[mShownPc]));
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence
  initial begin
    logic [7:0] wrapSeq [3];
    for (int i = 0; i < 256; i++) mem[i] = 20'(i);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge Clock);
    #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge Clock);
    checkOutput("rst_valid", 32'(instr_valid), 0);
    checkOutput("rst_addr", 32'(imem_addr), 0);
    checkOutput("rst_halted", 32'(halted), 0);

    // Straight-line fetch from 0
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge Clock);
      checkOutput("run_pc", 32'(instr_pc), k);
      checkOutput("run_valid", 32'(instr_valid), 1);
      checkOutput("run_instr", 32'(instruction), k);
    end

    // Stall for 3 cycles while instruction 5 is shown
    repeat (2) tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      checkOutput("stall_pc", 32'(instr_pc), 5);
      checkOutput("stall_instr", 32'(instruction), 5);
      checkOutput("stall_addr", 32'(imem_addr), 5);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    @(negedge Clock);
    checkOutput("unstall_pc", 32'(instr_pc), 6);

    // Redirect beats stall at instr_pc=7
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h40);
    @(negedge Clock);
    checkOutput("redir_addr", 32'(imem_addr), 32'h40);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge Clock);
    checkOutput("redir_pc", 32'(instr_pc), 32'h40);
    checkOutput("redir_valid", 32'(instr_valid), 1);
    tick();
    @(negedge Clock);
    checkOutput("redir_next", 32'(instr_pc), 32'h41);

    // HALT word at address 3, reached by redirecting to 1
    mem[3] = 20'hF0000;
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h01);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (2) tick();
    @(negedge Clock);
    checkOutput("halt_pc", 32'(instr_pc), 3);
    checkOutput("halt_shown_valid", 32'(instr_valid), 1);
    checkOutput("halt_word", 32'(instruction), 32'hF0000);
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge Clock);
      checkOutput("halted_valid", 32'(instr_valid), 0);
      checkOutput("halted_flag", 32'(halted), 1);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h10);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge Clock);
    checkOutput("unhalt_pc", 32'(instr_pc), 32'h10);
    checkOutput("unhalt_flag", 32'(halted), 0);
    checkOutput("unhalt_valid", 32'(instr_valid), 1);

    // Wrap-around after redirect to FE
    mem[3] = 20'h00003;
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hFE);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge Clock);
    checkOutput("wrap_pc", 32'(instr_pc), 32'hFE);
    wrapSeq[0] = 8'hFF;
    wrapSeq[1] = 8'h00;
    wrapSeq[2] = 8'h01;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge Clock);
      checkOutput("wrap_pc", 32'(instr_pc), 32'(wrapSeq[k]));
    end

    // Reset during a stall at instr_pc=9; BOOT then ignores stall
    repeat (8) tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    @(negedge Clock);
    checkOutput("pre_rst_pc", 32'(instr_pc), 9);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    @(negedge Clock);
    checkOutput("rst_stall_pc", 32'(instr_pc), 9);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    @(negedge Clock);
    checkOutput("rst2_valid", 32'(instr_valid), 0);
    checkOutput("rst2_addr", 32'(imem_addr), 0);
    tick();
    @(negedge Clock);
    checkOutput("boot_stall_pc", 32'(instr_pc), 0);
    checkOutput("boot_stall_valid", 32'(instr_valid), 1);
    checkOutput("boot_stall_addr", 32'(imem_addr), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    @(negedge Clock);
    checkOutput("after_boot_pc", 32'(instr_pc), 1);

    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
